// File: rtl/amns_bram_host_if.sv
// Bundle between the AMNS bridge-BRAM host and its environment: operand stream in,
// result stream out, second BRAM port and core start/done.
interface amns_bram_host_if #(
  parameter int WORD_WIDTH = 17
);
  logic [WORD_WIDTH-1:0] s_data_i;
  logic                  s_valid_i;
  logic                  s_ready_o;
  logic [WORD_WIDTH-1:0] m_data_o;
  logic                  m_valid_o;
  logic                  m_last_o;
  logic                  m_ready_i;
  logic [31:0]           bram_addr_o;
  logic [WORD_WIDTH-1:0] bram_din_o;
  logic [WORD_WIDTH-1:0] bram_dout_i;
  logic                  bram_we_o;
  logic                  bram_en_o;
  logic                  core_start_o;
  logic                  core_done_i;
  logic                  busy_o;

  modport master (
    input  s_data_i, s_valid_i, m_ready_i, bram_dout_i, core_done_i,
    output s_ready_o, m_data_o, m_valid_o, m_last_o, bram_addr_o, bram_din_o,
           bram_we_o, bram_en_o, core_start_o, busy_o
  );

  modport slave (
    output s_data_i, s_valid_i, m_ready_i, bram_dout_i, core_done_i,
    input  s_ready_o, m_data_o, m_valid_o, m_last_o, bram_addr_o, bram_din_o,
           bram_we_o, bram_en_o, core_start_o, busy_o
  );
endinterface

// File: rtl/amns_bram_host.sv
// Host master for the AMNS bridge BRAM: loads operands in core layout, kicks the core,
// then streams the N*s result words back out through a 2-entry skid FIFO.
//
// state    | meaning
// ST_IDLE  | ready for operand word 0
// ST_LOAD  | writing operand words 1..L-1 to address = load count
// ST_START | one-cycle core start pulse
// ST_WAIT  | BRAM port idle until core done
// ST_READ  | issuing result reads, draining FIFO to the result stream
module amns_bram_host #(
  parameter int s          = 4,
  parameter int N          = 5,
  parameter int WORD_WIDTH = 17,
  parameter int RES_BASE   = 0
) (
  input  logic               clock_i,
  input  logic               reset_i,
  amns_bram_host_if.master   bus
);
  localparam int L   = N * (3 * s + 1);
  localparam int NS  = N * s;
  localparam int LCW = $clog2(L + 1);
  localparam int RCW = $clog2(NS + 1);
  localparam int AW  = $clog2(4 * NS);

  typedef enum logic [2:0] {ST_IDLE, ST_LOAD, ST_START, ST_WAIT, ST_READ} state_t;

  state_t                state, state_nxt;
  logic [LCW-1:0]        load_cnt;
  logic [RCW-1:0]        rd_cnt;
  logic                  rd_pend, rd_pend_last;
  logic [WORD_WIDTH-1:0] fifo_data [2];
  logic [1:0]            fifo_last;
  logic                  wr_ptr, rd_ptr;
  logic [1:0]            fifo_occ;
  logic [2:0]            fifo_claim;
  logic                  s_hs, m_valid, m_hs, rd_issue;
  logic [AW-1:0]         rd_addr;

  assign s_hs     = (state == ST_IDLE || state == ST_LOAD) && bus.s_valid_i;
  assign m_valid  = (state == ST_READ) && (fifo_occ != 2'd0);
  assign m_hs     = m_valid && bus.m_ready_i;
  // Slots already owned (stored + in flight) after this cycle's pop; a read may claim one only if free.
  assign fifo_claim = 3'(fifo_occ) + 3'(rd_pend) - 3'(m_hs);
  assign rd_issue = (state == ST_READ) && (rd_cnt < RCW'(NS)) && (fifo_claim < 3'd2);
  assign rd_addr  = AW'(RES_BASE) + AW'(rd_cnt);

  always_ff @(posedge clock_i) begin
    if (reset_i) state <= ST_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt        = state;
    bus.s_ready_o    = 1'b0;
    bus.m_valid_o    = 1'b0;
    bus.m_data_o     = '0;
    bus.m_last_o     = 1'b0;
    bus.bram_addr_o  = '0;
    bus.bram_din_o   = '0;
    bus.bram_we_o    = 1'b0;
    bus.bram_en_o    = 1'b0;
    bus.core_start_o = 1'b0;
    bus.busy_o       = (state != ST_IDLE);
    case (state)
      ST_IDLE, ST_LOAD: begin
        bus.s_ready_o = 1'b1;
        if (bus.s_valid_i) begin
          bus.bram_en_o   = 1'b1;
          bus.bram_we_o   = 1'b1;
          bus.bram_addr_o = 32'(load_cnt);
          bus.bram_din_o  = bus.s_data_i;
          if (load_cnt == LCW'(L - 1)) state_nxt = ST_START;
          else                         state_nxt = ST_LOAD;
        end
      end
      ST_START: begin
        bus.core_start_o = 1'b1;
        state_nxt        = ST_WAIT;
      end
      ST_WAIT: begin
        if (bus.core_done_i) state_nxt = ST_READ;
      end
      ST_READ: begin
        bus.m_valid_o = m_valid;
        if (m_valid) begin
          bus.m_data_o = fifo_data[rd_ptr];
          bus.m_last_o = fifo_last[rd_ptr];
        end
        if (rd_issue) begin
          bus.bram_en_o   = 1'b1;
          bus.bram_addr_o = 32'(rd_addr);
        end
        if (m_hs && fifo_last[rd_ptr]) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      load_cnt     <= '0;
      rd_cnt       <= '0;
      rd_pend      <= 1'b0;
      rd_pend_last <= 1'b0;
      fifo_data[0] <= '0;
      fifo_data[1] <= '0;
      fifo_last    <= '0;
      wr_ptr       <= 1'b0;
      rd_ptr       <= 1'b0;
      fifo_occ     <= '0;
    end else begin
      if (state == ST_START) load_cnt <= '0;
      else if (s_hs)         load_cnt <= load_cnt + LCW'(1);

      if (rd_issue)               rd_cnt <= rd_cnt + RCW'(1);
      else if (state != ST_READ)  rd_cnt <= '0;

      rd_pend      <= rd_issue;
      rd_pend_last <= rd_issue && (rd_cnt == RCW'(NS - 1));

      if (rd_pend) begin
        fifo_data[wr_ptr] <= bus.bram_dout_i;
        fifo_last[wr_ptr] <= rd_pend_last;
        wr_ptr            <= ~wr_ptr;
      end
      if (m_hs) rd_ptr <= ~rd_ptr;

      case ({rd_pend, m_hs})
        2'b10:   fifo_occ <= fifo_occ + 2'd1;
        2'b01:   fifo_occ <= fifo_occ - 2'd1;
        default: fifo_occ <= fifo_occ;
      endcase
    end
  end
endmodule

// File: tb/tb_amns_bram_host.sv
// Randomised scoreboard bench for amns_bram_host: expected BRAM writes and result words are
// queued by the stimulus side and popped by an independent negedge monitor.
module tb_amns_bram_host;
  localparam int S        = 4;
  localparam int N        = 5;
  localparam int WW       = 17;
  localparam int RES_BASE = 0;
  localparam int L        = N * (3 * S + 1);
  localparam int NS       = N * S;

  logic clock_i = 1'b0;
  logic reset_i = 1'b1;
  always #5 clock_i = ~clock_i;

  amns_bram_host_if #(.WORD_WIDTH(WW)) bus ();

  amns_bram_host #(.s(S), .N(N), .WORD_WIDTH(WW), .RES_BASE(RES_BASE)) dut (
    .clock_i(clock_i),
    .reset_i(reset_i),
    .bus    (bus)
  );

  typedef struct {int addr; logic [WW-1:0] data;} wr_t;
  typedef struct {logic [WW-1:0] data; logic last;} rs_t;
  wr_t wq[$];
  rs_t rq[$];

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0, starts = 0, start_cyc = 0, last_wr_cyc = 0;
  int rd_idx = 0, rd_first_cyc = 0, res_cnt = 0, first_res_cyc = 0, last_res_cyc = 0;
  bit seen_start = 1'b0;
  bit stall_hold = 1'b0;
  logic [WW-1:0] stall_data = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock_i);
    #1;
  endtask

  // BRAM: reads return 0x100+addr one cycle later; otherwise the bus carries junk.
  always @(posedge clock_i) begin
    if (bus.bram_en_o && !bus.bram_we_o) bus.bram_dout_i <= WW'(32'h100 + bus.bram_addr_o);
    else                                 bus.bram_dout_i <= WW'($urandom);
  end

  always @(negedge clock_i) begin
    wr_t w;
    rs_t r;
    cyc++;
    if (reset_i) begin
      stall_hold = 1'b0;
    end else begin
      if (bus.bram_en_o && bus.bram_we_o) begin
        if (wq.size() == 0) begin
          check("unexpected_write", 32'(bus.bram_addr_o), 32'hFFFF_FFFF);
        end else begin
          w = wq.pop_front();
          check("wr_addr", bus.bram_addr_o, 32'(w.addr));
          check("wr_data", 32'(bus.bram_din_o), 32'(w.data));
          if (w.addr == L - 1) last_wr_cyc = cyc;
        end
      end
      if (!bus.bram_we_o) check("din_zero_no_we", 32'(bus.bram_din_o), 32'd0);
      if (bus.bram_en_o && !bus.bram_we_o) begin
        check("read_only_after_start", 32'(seen_start), 32'd1);
        check("rd_addr", bus.bram_addr_o, 32'(RES_BASE + rd_idx));
        if (rd_idx == 0) rd_first_cyc = cyc;
        rd_idx++;
      end
      if (bus.core_start_o) begin
        starts++;
        start_cyc  = cyc;
        seen_start = 1'b1;
      end
      if (stall_hold) begin
        check("stall_valid", 32'(bus.m_valid_o), 32'd1);
        check("stall_data", 32'(bus.m_data_o), 32'(stall_data));
      end
      if (bus.m_valid_o && bus.m_ready_i) begin
        if (rq.size() == 0) begin
          check("unexpected_result", 32'(bus.m_data_o), 32'hFFFF_FFFF);
        end else begin
          if (rq.size() == NS) first_res_cyc = cyc;
          r = rq.pop_front();
          check("res_data", 32'(bus.m_data_o), 32'(r.data));
          check("res_last", 32'(bus.m_last_o), 32'(r.last));
          res_cnt++;
          last_res_cyc = cyc;
        end
      end
      if (!bus.busy_o) check("valid_low_idle", 32'(bus.m_valid_o), 32'd0);
      stall_hold = bus.m_valid_o && !bus.m_ready_i;
      stall_data = bus.m_data_o;
    end
  end

  task automatic check_idle_outputs(input string tag);
    check({tag, "_s_ready"}, 32'(bus.s_ready_o), 32'd1);
    check({tag, "_busy"}, 32'(bus.busy_o), 32'd0);
    check({tag, "_m_valid"}, 32'(bus.m_valid_o), 32'd0);
    check({tag, "_m_last"}, 32'(bus.m_last_o), 32'd0);
    check({tag, "_m_data"}, 32'(bus.m_data_o), 32'd0);
    check({tag, "_en"}, 32'(bus.bram_en_o), 32'd0);
    check({tag, "_we"}, 32'(bus.bram_we_o), 32'd0);
    check({tag, "_addr"}, bus.bram_addr_o, 32'd0);
    check({tag, "_start"}, 32'(bus.core_start_o), 32'd0);
  endtask

  task automatic do_reset();
    reset_i = 1'b1;
    bus.s_valid_i = 1'b0;
    bus.s_data_i = '0;
    bus.m_ready_i = 1'b0;
    bus.core_done_i = 1'b0;
    repeat (3) tick();
    @(negedge clock_i);
    check_idle_outputs("reset");
    @(posedge clock_i);
    #1;
    reset_i = 1'b0;
    @(negedge clock_i);
    check_idle_outputs("post_reset");
    @(posedge clock_i);
    #1;
  endtask

  task automatic begin_txn();
    seen_start = 1'b0;
    rd_idx = 0;
  endtask

  task automatic load_stream(input int gap_pct, input int nwords, input bit seq_data);
    wr_t w;
    int k = 0;
    while (k < nwords) begin
      if ($urandom_range(99) < gap_pct) begin
        bus.s_valid_i = 1'b0;
        bus.s_data_i = WW'($urandom);
      end else begin
        bus.s_valid_i = 1'b1;
        bus.s_data_i = seq_data ? WW'(k) : WW'($urandom);
        w.addr = k;
        w.data = bus.s_data_i;
        wq.push_back(w);
        k++;
      end
      tick();
    end
    bus.s_valid_i = 1'b0;
    bus.s_data_i = '0;
  endtask

  task automatic finish_load(input int starts_before);
    @(negedge clock_i);
    check("start_pulse", 32'(bus.core_start_o), 32'd1);
    check("ready_low_after_load", 32'(bus.s_ready_o), 32'd0);
    check("busy_in_start", 32'(bus.busy_o), 32'd1);
    @(negedge clock_i);
    check("start_one_cycle", 32'(bus.core_start_o), 32'd0);
    check("start_after_last_word", 32'(start_cyc - last_wr_cyc), 32'd1);
    check("start_count", 32'(starts), 32'(starts_before + 1));
    check("writes_drained", 32'(wq.size()), 32'd0);
    @(posedge clock_i);
    #1;
  endtask

  task automatic run_read(input int rdy_pct, input bit pulse_done);
    rs_t r;
    int res0 = res_cnt;
    int c;
    for (int i = 0; i < NS; i++) begin
      r.data = WW'(32'h100 + RES_BASE + i);
      r.last = (i == NS - 1);
      rq.push_back(r);
    end
    bus.m_ready_i = (rdy_pct >= 100);
    if (pulse_done) begin
      repeat ($urandom_range(3)) tick();
      check("wait_idle_port", 32'(rd_idx), 32'd0);
      bus.core_done_i = 1'b1;
      tick();
      bus.core_done_i = 1'b0;
    end
    c = 0;
    while (bus.busy_o && c < 1000) begin
      bus.m_ready_i = ($urandom_range(99) < rdy_pct);
      tick();
      c++;
    end
    check("read_timeout", 32'(bus.busy_o), 32'd0);
    check("result_count", 32'(res_cnt - res0), 32'(NS));
    check("read_count", 32'(rd_idx), 32'(NS));
    check("results_drained", 32'(rq.size()), 32'd0);
    if (rdy_pct >= 100) begin
      check("first_result_latency", 32'(first_res_cyc - rd_first_cyc), 32'd2);
      check("results_back_to_back", 32'(last_res_cyc - first_res_cyc), 32'(NS - 1));
    end
    bus.m_ready_i = 1'b0;
    rq.delete();
    @(negedge clock_i);
    check("back_idle_ready", 32'(bus.s_ready_o), 32'd1);
    @(posedge clock_i);
    #1;
  endtask

  task automatic full_txn(input int gap_pct, input bit seq_data, input int rdy_pct, input bit hold_done);
    int sb;
    begin_txn();
    sb = starts;
    if (hold_done) bus.core_done_i = 1'b1;
    load_stream(gap_pct, L, seq_data);
    finish_load(sb);
    run_read(rdy_pct, !hold_done);
    bus.core_done_i = 1'b0;
  endtask

  initial begin
    int sb;
    bus.bram_dout_i = '0;
    do_reset();

    full_txn(0, 1'b1, 100, 1'b0);
    full_txn(40, 1'b0, 100, 1'b0);
    full_txn(40, 1'b0, 50, 1'b0);
    full_txn(20, 1'b0, 70, 1'b1);

    begin_txn();
    sb = starts;
    load_stream(0, 31, 1'b1);
    reset_i = 1'b1;
    tick();
    tick();
    reset_i = 1'b0;
    wq.delete();
    @(negedge clock_i);
    check("abort_no_start", 32'(starts), 32'(sb));
    check_idle_outputs("abort");
    @(posedge clock_i);
    #1;
    full_txn(30, 1'b1, 60, 1'b0);
    full_txn(10, 1'b0, 100, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end
endmodule
